// File: rtl/vga_pkg.sv
// Shared types and frame-store geometry for the VGA frame-composition controller.
package vga_pkg;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int PIX_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_POS,
    ST_BLIT,
    ST_WAIT_VS,
    ST_SWAP
  } blit_state_e;

  typedef struct packed {
    logic [7:0] y;
    logic [8:0] x;
  } sprite_pos_t;

endpackage

// File: rtl/vga_blit_addr.sv
// Maps a sprite pixel (slot origin + col/row offset) to a linear back-buffer address and clip flag.
module vga_blit_addr
  import vga_pkg::*;
#(
  parameter int FB_W = vga_pkg::FB_W,
  parameter int FB_H = vga_pkg::FB_H,
  parameter int CW   = 4
) (
  input  sprite_pos_t     pos,
  input  logic [CW-1:0]   col,
  input  logic [CW-1:0]   row,
  output logic [16:0]     addr,
  output logic            in_bounds
);

  localparam logic [9:0]  X_LIM   = 10'(FB_W);
  localparam logic [9:0]  Y_LIM   = 10'(FB_H);
  localparam logic [16:0] ROW_LEN = 17'(FB_W);

  logic [9:0] xs;
  logic [9:0] ys;

  // 10-bit sums so a sprite hanging off the right/bottom edge clips instead of wrapping
  assign xs = {1'b0, pos.x} + 10'(col);
  assign ys = {2'b0, pos.y} + 10'(row);

  assign in_bounds = (xs < X_LIM) && (ys < Y_LIM);
  // constant multiply; for a 320-wide store this is (ys<<8)+(ys<<6)
  assign addr      = (17'(ys) * ROW_LEN) + 17'(xs);

endmodule

// File: rtl/vga_blit_sched.sv
// Frame composer: clear back buffer, blit visible ROM sprites in slot order, flip on vsync falling edge.
module vga_blit_sched
  import vga_pkg::*;
#(
  parameter int               NUM_SPRITES = 32,
  parameter int               SPR_DIM     = 16,
  parameter int               FB_W        = vga_pkg::FB_W,
  parameter int               FB_H        = vga_pkg::FB_H,
  parameter logic [PIX_W-1:0] TRANSP_KEY  = 12'h000
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_i,
  input  logic                                   start_i,
  input  logic [PIX_W-1:0]                       bg_color_i,
  input  logic                                   vs_i,
  output logic [$clog2(NUM_SPRITES)-1:0]         slot_sel_o,
  input  logic [16:0]                            slot_pos_i,
  output logic [$clog2(SPR_DIM*SPR_DIM)-1:0]     rom_addr_o,
  input  logic [PIX_W-1:0]                       rom_data_i,
  output logic [16:0]                            fb_addr_o,
  output logic [PIX_W-1:0]                       fb_data_o,
  output logic                                   fb_we_o,
  output logic                                   frame_sel_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output blit_state_e                            dbg_state
);

  localparam int SW = $clog2(NUM_SPRITES);
  localparam int RW = $clog2(SPR_DIM*SPR_DIM);
  localparam int CW = $clog2(SPR_DIM);

  localparam logic [16:0]   LAST_PIX  = 17'(FB_W*FB_H - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SPRITES - 1);
  localparam logic [RW:0]   BLIT_END  = (RW+1)'(SPR_DIM*SPR_DIM);
  localparam logic [8:0]    X_LIM     = 9'(FB_W);
  localparam logic [7:0]    Y_LIM     = 8'(FB_H);

  blit_state_e      state;
  blit_state_e      state_nx;
  logic [PIX_W-1:0] bg_q;
  logic [16:0]      clr_addr;
  logic [SW-1:0]    slot_cnt;
  logic [SW-1:0]    slot_sel_q;
  sprite_pos_t      pos_in;
  sprite_pos_t      pos_q;
  logic [RW:0]      rom_cnt;
  logic             pipe_valid;
  logic [RW-1:0]    pipe_idx;
  logic             vs_q;
  logic             frame_sel_q;
  logic             vs_fall;
  logic             pos_hidden;
  logic             last_slot;
  logic [16:0]      pix_addr;
  logic             pix_in;

  assign pos_in     = sprite_pos_t'(slot_pos_i);
  assign pos_hidden = (pos_in.x >= X_LIM) || (pos_in.y >= Y_LIM);
  assign last_slot  = (slot_cnt == LAST_SLOT);
  assign vs_fall    = vs_q && !vs_i;

  vga_blit_addr #(.FB_W(FB_W), .FB_H(FB_H), .CW(CW)) u_addr (
    .pos       (pos_q),
    .col       (pipe_idx[CW-1:0]),
    .row       (pipe_idx[RW-1:CW]),
    .addr      (pix_addr),
    .in_bounds (pix_in)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bg_q        <= '0;
      clr_addr    <= '0;
      slot_cnt    <= '0;
      slot_sel_q  <= '0;
      pos_q       <= '0;
      rom_cnt     <= '0;
      pipe_valid  <= 1'b0;
      pipe_idx    <= '0;
      vs_q        <= 1'b1;
      frame_sel_q <= 1'b0;
    end else begin
      vs_q       <= vs_i;
      // ROM data lags its address by one cycle, so the write stage trails the address stage
      pipe_valid <= (state == ST_BLIT) && !rom_cnt[RW];
      pipe_idx   <= rom_cnt[RW-1:0];
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            bg_q     <= bg_color_i;
            slot_cnt <= '0;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: clr_addr <= clr_addr + 17'd1;
        ST_POS: begin
          slot_sel_q <= slot_cnt;
          pos_q      <= pos_in;
          rom_cnt    <= '0;
          if (pos_hidden && !last_slot) slot_cnt <= slot_cnt + 1'b1;
        end
        ST_BLIT: begin
          rom_cnt <= rom_cnt + 1'b1;
          if ((rom_cnt == BLIT_END) && !last_slot) slot_cnt <= slot_cnt + 1'b1;
        end
        ST_WAIT_VS: if (vs_fall) frame_sel_q <= ~frame_sel_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    fb_we_o   = 1'b0;
    fb_addr_o = '0;
    fb_data_o = '0;
    case (state)
      ST_IDLE:  if (start_i) state_nx = ST_CLEAR;
      ST_CLEAR: begin
        fb_we_o   = 1'b1;
        fb_addr_o = clr_addr;
        fb_data_o = bg_q;
        if (clr_addr == LAST_PIX) state_nx = ST_POS;
      end
      ST_POS: begin
        if (!pos_hidden)   state_nx = ST_BLIT;
        else if (last_slot) state_nx = ST_WAIT_VS;
      end
      ST_BLIT: begin
        fb_addr_o = pix_addr;
        fb_data_o = rom_data_i;
        fb_we_o   = pipe_valid && pix_in && (rom_data_i != TRANSP_KEY);
        if (rom_cnt == BLIT_END) state_nx = last_slot ? ST_WAIT_VS : ST_POS;
      end
      ST_WAIT_VS: if (vs_fall) state_nx = ST_SWAP;
      ST_SWAP:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // slot_sel_o must be live during POS for the combinational position lookup, frozen otherwise
  assign slot_sel_o  = (state == ST_POS) ? slot_cnt : slot_sel_q;
  assign rom_addr_o  = (state == ST_BLIT) ? rom_cnt[RW-1:0] : '0;
  assign frame_sel_o = frame_sel_q;
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_SWAP);
  assign dbg_state   = state;

endmodule

// File: tb/tb_vga_blit_sched.sv
// Directed bench for vga_blit_sched on a reduced 64x48 store so every scenario fits in a short run.
module tb_vga_blit_sched;
  import vga_pkg::*;

  localparam int TW = 64;
  localparam int TH = 48;
  localparam int NP = TW * TH;
  localparam int LIM = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] bg_color_i = '0;
  logic        vs_i = 1'b1;
  logic [4:0]  slot_sel_o;
  logic [16:0] slot_pos_i;
  logic [7:0]  rom_addr_o;
  logic [11:0] rom_data_i = '0;
  logic [16:0] fb_addr_o;
  logic [11:0] fb_data_o;
  logic        fb_we_o;
  logic        frame_sel_o;
  logic        busy_o;
  logic        done_o;
  blit_state_e dbg_state;

  logic [16:0] pos_tbl [32];
  logic [11:0] spr_color [32];
  logic        checker_mode = 1'b0;

  int tests = 0;
  int fails = 0;
  logic exp_fsel = 1'b0;

  // frame monitor configuration and counters
  int          frame_id = 0;
  int          seen_id = 0;
  logic [11:0] bg_exp = '0;
  logic [11:0] blit_data = '0;
  bit          chk_data = 1'b0;
  bit          seq_check = 1'b0;
  int          rx0 = 0, ry0 = 0, rw = 0, rh = 0;
  int          wr_cnt = 0, clr_err = 0, blit_cnt = 0, bad_data = 0;
  int          in_rect = 0, out_rect = 0, q_err = 0;
  logic [11:0] shadow [NP];
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  vga_blit_sched #(.FB_W(TW), .FB_H(TH)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start_i),
    .bg_color_i  (bg_color_i),
    .vs_i        (vs_i),
    .slot_sel_o  (slot_sel_o),
    .slot_pos_i  (slot_pos_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .fb_addr_o   (fb_addr_o),
    .fb_data_o   (fb_data_o),
    .fb_we_o     (fb_we_o),
    .frame_sel_o (frame_sel_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state   (dbg_state)
  );

  assign slot_pos_i = pos_tbl[slot_sel_o];

  always @(posedge clk)
    rom_data_i <= checker_mode ? ((rom_addr_o[0] ^ rom_addr_o[4]) ? 12'hFFF : 12'h000)
                               : spr_color[slot_sel_o];

  function automatic bit in_rect_f(input logic [16:0] a);
    int ax, ay;
    ax = int'(a) % TW;
    ay = int'(a) / TW;
    return (ax >= rx0) && (ax < rx0 + rw) && (ay >= ry0) && (ay < ry0 + rh);
  endfunction

  always @(negedge clk) begin
    if (frame_id != seen_id) begin
      seen_id  <= frame_id;
      wr_cnt   <= 0;
      clr_err  <= 0;
      blit_cnt <= 0;
      bad_data <= 0;
      in_rect  <= 0;
      out_rect <= 0;
      q_err    <= 0;
      exp_q.delete();
      if (seq_check)
        for (int r = 0; r < 16; r++)
          for (int c = 0; c < 16; c++)
            exp_q.push_back(17'((ry0 + r) * TW + rx0 + c));
    end else if (!rst && fb_we_o) begin
      wr_cnt <= wr_cnt + 1;
      if (wr_cnt < NP) begin
        if (fb_addr_o !== 17'(wr_cnt) || fb_data_o !== bg_exp) clr_err <= clr_err + 1;
      end else begin
        blit_cnt <= blit_cnt + 1;
        if (chk_data && fb_data_o !== blit_data) bad_data <= bad_data + 1;
        if (in_rect_f(fb_addr_o)) in_rect <= in_rect + 1;
        else                      out_rect <= out_rect + 1;
        if (exp_q.size() != 0) begin
          if (exp_q.pop_front() !== fb_addr_o) q_err <= q_err + 1;
        end else if (seq_check) q_err <= q_err + 1;
      end
      if (int'(fb_addr_o) < NP) shadow[fb_addr_o] <= fb_data_o;
      else                      out_rect <= out_rect + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic hide_all();
    for (int i = 0; i < 32; i++) begin
      pos_tbl[i]   = 17'h1FFFF;
      spr_color[i] = 12'h000;
    end
    checker_mode = 1'b0;
  endtask

  task automatic set_mon(input int x0, input int y0, input int w, input int h,
                         input bit cd, input logic [11:0] d, input bit sq);
    rx0 = x0; ry0 = y0; rw = w; rh = h;
    chk_data = cd; blit_data = d; seq_check = sq;
  endtask

  // one full frame: start, composition, vsync-driven flip; poke adds a start while busy
  task automatic run_frame(input string tag, input logic [11:0] bg, input int exp_lat,
                           input bit vs_pre, input bit poke);
    int n;
    bg_exp = bg;
    frame_id++;
    @(negedge clk);
    bg_color_i = bg;
    start_i    = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
    bg_color_i = ~bg;
    n = 1;
    check({tag, "_busy"}, busy_o, 1);
    if (vs_pre) vs_i = 1'b0;
    while (dbg_state != ST_WAIT_VS && n < LIM) begin
      start_i = poke && (n == 5);
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    repeat (3) @(negedge clk);
    check({tag, "_hold_done"}, done_o, 0);
    check({tag, "_hold_fsel"}, frame_sel_o, exp_fsel);
    if (vs_pre) begin
      vs_i = 1'b1;
      @(negedge clk);
      check({tag, "_rise_done"}, done_o, 0);
    end
    vs_i = 1'b0;
    @(negedge clk);
    exp_fsel = ~exp_fsel;
    check({tag, "_done"}, done_o, 1);
    check({tag, "_fsel"}, frame_sel_o, exp_fsel);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    vs_i    = 1'b1;
    check({tag, "_done_end"}, done_o, 0);
    check({tag, "_idle"}, busy_o, 0);
    @(negedge clk);
    check({tag, "_swap_start_ign"}, busy_o, 0);
  endtask

  initial begin
    int n;
    hide_all();
    repeat (3) @(negedge clk);
    check("rst_we", fb_we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fsel", frame_sel_o, 0);
    check("rst_slot", slot_sel_o, 0);
    check("rst_rom", rom_addr_o, 0);
    check("rst_fbaddr", fb_addr_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", dbg_state, ST_IDLE);

    // 1: all hidden, pure clear
    set_mon(0, 0, 0, 0, 1'b0, 12'h000, 1'b0);
    run_frame("t1", 12'h00F, NP + 33, 1'b0, 1'b0);
    check("t1_writes", wr_cnt, NP);
    check("t1_clr_err", clr_err, 0);
    check("t1_last_pix", shadow[NP-1], 12'h00F);

    // 2: one solid sprite, exact row-major address order
    pos_tbl[3]   = {8'd20, 9'd10};
    spr_color[3] = 12'hABC;
    set_mon(10, 20, 16, 16, 1'b1, 12'hABC, 1'b1);
    run_frame("t2", 12'h123, NP + 33 + 257, 1'b0, 1'b0);
    check("t2_clr_err", clr_err, 0);
    check("t2_blits", blit_cnt, 256);
    check("t2_order", q_err, 0);
    check("t2_data", bad_data, 0);
    check("t2_first", shadow[20*TW+10], 12'hABC);
    check("t2_last", shadow[35*TW+25], 12'hABC);
    check("t2_outside", shadow[20*TW+26], 12'h123);

    // 3: bottom-right clipping; slots exactly at the limits are hidden
    hide_all();
    pos_tbl[0]   = {8'(TH - 8), 9'(TW - 8)};
    spr_color[0] = 12'h5A5;
    pos_tbl[5]   = {8'd0, 9'(TW)};
    spr_color[5] = 12'h777;
    pos_tbl[6]   = {8'(TH), 9'd0};
    spr_color[6] = 12'h777;
    set_mon(TW - 8, TH - 8, 8, 8, 1'b1, 12'h5A5, 1'b0);
    run_frame("t3", 12'h321, NP + 33 + 257, 1'b1, 1'b0);
    check("t3_blits", blit_cnt, 64);
    check("t3_in_rect", in_rect, 64);
    check("t3_out_rect", out_rect, 0);
    check("t3_data", bad_data, 0);

    // 4: checkerboard ROM, zero pixels transparent
    hide_all();
    pos_tbl[7]   = {8'd0, 9'd0};
    checker_mode = 1'b1;
    set_mon(0, 0, 16, 16, 1'b1, 12'hFFF, 1'b0);
    run_frame("t4", 12'h0F0, NP + 33 + 257, 1'b0, 1'b0);
    check("t4_blits", blit_cnt, 128);
    check("t4_data", bad_data, 0);
    check("t4_pix0_transp", shadow[0], 12'h0F0);
    check("t4_pix1", shadow[1], 12'hFFF);

    // 5: overlapping slots 0 and 31, later slot wins
    hide_all();
    pos_tbl[0]    = {8'd0, 9'd0};
    spr_color[0]  = 12'h111;
    pos_tbl[31]   = {8'd0, 9'd0};
    spr_color[31] = 12'h222;
    set_mon(0, 0, 16, 16, 1'b0, 12'h000, 1'b0);
    run_frame("t5", 12'h0F0, NP + 33 + 514, 1'b0, 1'b0);
    check("t5_blits", blit_cnt, 512);
    check("t5_in_rect", in_rect, 512);
    check("t5_pix0", shadow[0], 12'h222);
    check("t5_pix_15_15", shadow[15*TW+15], 12'h222);

    // 6: reset during BLIT, then two frames toggling the buffer back to 0
    hide_all();
    pos_tbl[3]   = {8'd20, 9'd10};
    spr_color[3] = 12'hABC;
    set_mon(0, 0, 0, 0, 1'b0, 12'h000, 1'b0);
    bg_exp = 12'h444;
    frame_id++;
    @(negedge clk);
    bg_color_i = 12'h444;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (dbg_state != ST_BLIT && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_blit", dbg_state, ST_BLIT);
    repeat (5) @(negedge clk);
    check("t6_pre_rst_we", fb_we_o, 1);
    check("t6_pre_rst_fsel", frame_sel_o, 1);
    #1 rst = 1'b1;
    #1;
    exp_fsel = 1'b0;
    check("t6_rst_we", fb_we_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_fsel", frame_sel_o, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    hide_all();
    @(negedge clk);
    run_frame("t6a", 12'h456, NP + 33, 1'b0, 1'b1);
    check("t6a_writes", wr_cnt, NP);
    check("t6a_clr_err", clr_err, 0);
    run_frame("t6b", 12'h789, NP + 33, 1'b0, 1'b0);
    check("t6b_fsel_back", frame_sel_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
